fp_mul_sched: RTL and testbench

- Round-robin scheduler that shares one combinational IEEE-754 single-precision multiplier among NUM_REQ requesters.
- The multiplier sits outside this block and is either the exact or the approximate variant. It is driven through the mul_* ports, and the approximate variant takes a 22-bit approximation-config word.
- The scheduler adds a two-stage pipeline (operand register, result register), valid/ready handshakes on both sides, and returns each result tagged with the requester id.
- It sits between the accelerator's compute lanes and the shared multiplier.

---
 rtl/fp_mul_sched_pkg.sv | 17 +
 rtl/fp_mul_sched_rr_arbiter.sv | 47 ++++
 rtl/fp_mul_sched.sv | 148 ++++++++++++++
 tb/tb_fp_mul_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_sched_pkg.sv
// fp_mul_sched_pkg
// Shared types and constants for the shared-multiplier scheduler.
//   FP_W / CFG_W_DEF : default operand and approximation-config widths
//   fp32_t           : IEEE-754 single-precision word
//   approx_cfg_t     : approximate-multiplier configuration word
//   CFG_EXACT        : all-ones config, selects full-precision mode
package fp_mul_sched_pkg;

  localparam int FP_W      = 32;
  localparam int CFG_W_DEF = 22;

  typedef logic [FP_W-1:0]      fp32_t;
  typedef logic [CFG_W_DEF-1:0] approx_cfg_t;

  localparam approx_cfg_t CFG_EXACT = 22'h3FFFFF;

endpackage

// File: rtl/fp_mul_sched_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. The scan starts at ptr and wraps
// modulo N; the first requesting index wins.
//   req     : request vector
//   ptr     : highest-priority index for this cycle (must be < N)
//   en      : when low, gnt is forced to zero (gnt_idx still reports the winner)
//   gnt     : one-hot grant, or zero when nothing requests or en is low
//   gnt_idx : binary index of the winner (0 when nothing requests)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // cand_idx[k] is the requester examined k places after ptr. ptr < N, so
  // the sum is below 2N and a single conditional subtract performs the wrap.
  logic [IW-1:0] cand_idx [N];
  logic          found;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign cand_idx[gi] = (int'(ptr) + gi >= N) ? IW'(int'(ptr) + gi - N)
                                                  : IW'(int'(ptr) + gi);
    end
  endgenerate

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[cand_idx[k]]) begin
        found   = 1'b1;
        gnt_idx = cand_idx[k];
      end
    end
    if (en && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// fp_mul_sched
// Round-robin scheduler sharing one external combinational FP32 multiplier
// among NUM_REQ requesters. Two pipeline stages: S1 holds the operands that
// drive the multiplier, S2 captures the product and presents it to the
// consumer together with the issuing requester id.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b, req_cfg : packed per-requester operands and config
//   mul_a, mul_b, mul_cfg : registered multiplier inputs
//   mul_res               : multiplier result (combinational from mul_*)
//   rsp_valid/rsp_ready   : result handshake
//   rsp_data, rsp_id      : product and issuing requester
//   busy                  : either pipeline stage occupied
// Optional build macro FP_MUL_SCHED_STATS_EN adds per-requester saturating
// grant counters (stat_grants) with a synchronous clear input (stat_clr).
module fp_mul_sched
  import fp_mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = FP_W,
  parameter int CFG_W   = CFG_W_DEF,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*CFG_W-1:0]  req_cfg,
  output logic [DATA_W-1:0]         mul_a,
  output logic [DATA_W-1:0]         mul_b,
  output logic [CFG_W-1:0]          mul_cfg,
  input  logic [DATA_W-1:0]         mul_res,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy
`ifdef FP_MUL_SCHED_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NUM_REQ*16-1:0]     stat_grants
`endif
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic              s1_v;
  logic              s2_v;
  logic [ID_W-1:0]   s1_id;
  logic [ID_W-1:0]   ptr;
  logic              adv2;
  logic              can_issue;
  logic              issue;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;

  logic [DATA_W-1:0] a_arr   [NUM_REQ];
  logic [DATA_W-1:0] b_arr   [NUM_REQ];
  logic [CFG_W-1:0]  cfg_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
      assign cfg_arr[gi] = req_cfg[gi*CFG_W +: CFG_W];
    end
  endgenerate

  // S1 moves into S2 whenever S2 is empty or being drained this cycle; S1 can
  // then take a new operand pair in the same cycle.
  assign adv2      = s1_v & (~s2_v | rsp_ready);
  assign can_issue = ~s1_v | adv2;

  // rst gates the arbiter so req_ready drops immediately on an asynchronous
  // reset, not only after the next clock edge.
  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (can_issue & ~rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign issue     = |gnt;   // gnt only asserts on a valid requester
  assign rsp_valid = s2_v;
  assign busy      = s1_v | s2_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s2_v     <= 1'b0;
      s1_id    <= '0;
      ptr      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_cfg  <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      // S2: capture takes priority over drain; both together keep s2_v set.
      if (adv2) begin
        rsp_data <= mul_res;
        rsp_id   <= s1_id;
        s2_v     <= 1'b1;
      end else if (s2_v && rsp_ready) begin
        s2_v <= 1'b0;
      end

      // S1: on an empty advance the multiplier inputs keep their old value.
      if (issue) begin
        mul_a   <= a_arr[gnt_idx];
        mul_b   <= b_arr[gnt_idx];
        mul_cfg <= cfg_arr[gnt_idx];
        s1_id   <= gnt_idx;
        s1_v    <= 1'b1;
        ptr     <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + ID_W'(1);
      end else if (adv2) begin
        s1_v <= 1'b0;
      end
    end
  end

`ifdef FP_MUL_SCHED_STATS_EN
  logic [15:0] stat_cnt [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stat
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stat_cnt[gi] <= '0;
        end else if (stat_clr) begin
          stat_cnt[gi] <= '0;
        end else if (gnt[gi] && (stat_cnt[gi] != 16'hFFFF)) begin
          stat_cnt[gi] <= stat_cnt[gi] + 16'd1;
        end
      end
      assign stat_grants[gi*16 +: 16] = stat_cnt[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fp_mul_sched.sv
// tb_fp_mul_sched
// Self-checking bench for fp_mul_sched. A behavioural FP32 multiplier drives
// mul_res (exact for the small-integer operands used here, with the low
// result bits XORed by ~cfg so config routing is observable). A scoreboard
// queue receives the expected product on every request handshake and is
// compared on every response handshake.
// Define FP_MUL_SCHED_STATS_EN to also exercise the grant counters.
module tb_fp_mul_sched;
  import fp_mul_sched_pkg::*;

  localparam int N = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic [N*22-1:0] req_cfg;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [21:0]     mul_cfg;
  logic [31:0]     mul_res;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_data;
  logic [1:0]      rsp_id;
  logic            busy;
`ifdef FP_MUL_SCHED_STATS_EN
  logic            stat_clr;
  logic [N*16-1:0] stat_grants;
`endif

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          grant_log[$];
  int          checks = 0;
  int          errors = 0;
  int          hs_count = 0;
  logic [N-1:0] hold_mask;

  fp_mul_sched #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cfg   (req_cfg),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_cfg   (mul_cfg),
    .mul_res   (mul_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef FP_MUL_SCHED_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grants (stat_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] int_to_fp(input int k, input bit neg);
    int p;
    logic [31:0] m;
    p = 0;
    for (int j = 0; j < 31; j++) if (k[j]) p = j;
    m = 32'(k) << (23 - p);
    return {neg, 8'(127 + p), m[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul_model(input logic [31:0] a, input logic [31:0] b,
                                               input logic [21:0] cfg);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    return {a[31] ^ b[31], e[7:0], m} ^ {10'b0, ~cfg};
  endfunction

  assign mul_res = fp_mul_model(mul_a, mul_b, mul_cfg);

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: 2'(i),
                         data: fp_mul_model(req_a[i*32 +: 32], req_b[i*32 +: 32],
                                            req_cfg[i*22 +: 22])});
          grant_log.push_back(i);
        end
      end
      checks++;
      if (((req_ready & ~req_valid) != '0) || ($countones(req_ready) > 1)) begin
        errors++;
        $display("FAIL ready_legal: req_ready=%b req_valid=%b", req_ready, req_valid);
      end
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d data=%h, none expected", rsp_id, rsp_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_data !== e.data || rsp_id !== e.id) begin
            errors++;
            $display("FAIL rsp_match: got id=%0d data=%h expected id=%0d data=%h",
                     rsp_id, rsp_data, e.id, e.data);
          end else begin
            $display("rsp id=%0d data=%h ok", rsp_id, rsp_data);
          end
        end
      end
    end
  end

  task automatic new_operands(input int i);
    req_a[i*32 +: 32] = int_to_fp($urandom_range(1, 60), 1'($urandom_range(0, 1)));
    req_b[i*32 +: 32] = int_to_fp($urandom_range(1, 60), 1'($urandom_range(0, 1)));
    req_cfg[i*22 +: 22] = 22'($urandom());
  endtask

  // One clock: record handshakes, then after the edge refresh the operands of
  // every granted requester and drop valid unless it is held.
  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    hs_count += $countones(hs);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        new_operands(i);
        if (!hold_mask[i]) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    req_valid = '0;
    hold_mask = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      tick();
    end
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL drain: busy=%b pending=%0d expected busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    hold_mask = '0;
    for (int i = 0; i < N; i++) new_operands(i);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || mul_a !== '0 ||
        mul_b !== '0 || mul_cfg !== '0 || rsp_data !== '0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_state: rsp_valid=%b busy=%b req_ready=%b mul_a=%h rsp_data=%h rsp_id=%0d expected all 0",
               rsp_valid, busy, req_ready, mul_a, rsp_data, rsp_id);
    end
    req_valid = '0;
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single();
    req_a[32 +: 32] = 32'h40400000;
    req_b[32 +: 32] = 32'h40000000;
    req_cfg[22 +: 22] = CFG_EXACT;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL single_ready: got %b expected 0010", req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || mul_a !== 32'h40400000) begin
      errors++;
      $display("FAIL single_s1: rsp_valid=%b busy=%b mul_a=%h expected 0 1 40400000",
               rsp_valid, busy, mul_a);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h40C00000 || rsp_id !== 2'd1) begin
      errors++;
      $display("FAIL single_rsp: valid=%b data=%h id=%0d expected 1 40C00000 1",
               rsp_valid, rsp_data, rsp_id);
    end
    drain();
    $display("test_single done");
  endtask

  task automatic test_fairness();
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    grant_log.delete();
    hold_mask = '1;
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1) begin
          errors++;
          $display("FAIL throughput: cycle %0d rsp_valid=%b expected 1", c, rsp_valid);
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (grant_log.size() <= k || grant_log[k] != exp_order[k]) begin
        errors++;
        $display("FAIL grant_order[%0d]: got %0d expected %0d", k,
                 (grant_log.size() > k) ? grant_log[k] : -1, exp_order[k]);
      end
    end
    drain();
    $display("test_fairness done");
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic [1:0]  id;
    rsp_ready = 1'b0;
    hold_mask = '1;
    req_valid = '1;
    hs_count = 0;
    repeat (2) tick();
    d  = rsp_data;
    id = rsp_id;
    repeat (3) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_id !== id) begin
        errors++;
        $display("FAIL rsp_stable: valid=%b data=%h id=%0d expected 1 %h %0d",
                 rsp_valid, rsp_data, rsp_id, d, id);
      end
    end
    checks++;
    if (hs_count != 2 || req_ready !== '0) begin
      errors++;
      $display("FAIL bp_accept: accepted=%0d req_ready=%b expected 2 0000", hs_count, req_ready);
    end
    $display("test_backpressure done");
  endtask

  // Entered with both stages full and every requester valid.
  task automatic test_simultaneous();
    rsp_ready = 1'b1;
    #1;
    checks++;
    if ($countones(req_ready) != 1 || rsp_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL simul_issue: req_ready=%b rsp_valid=%b busy=%b expected one-hot 1 1",
               req_ready, rsp_valid, busy);
    end
    tick();
    checks++;
    if (hs_count != 3 || rsp_valid !== 1'b1 || sb.size() != 2) begin
      errors++;
      $display("FAIL simul_after: accepted=%0d rsp_valid=%b pending=%0d expected 3 1 2",
               hs_count, rsp_valid, sb.size());
    end
    drain();
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    hold_mask = '1;
    req_valid = '1;
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || mul_a !== '0 ||
        rsp_data !== '0 || rsp_id !== '0) begin
      errors++;
      $display("FAIL reset_mid: rsp_valid=%b busy=%b req_ready=%b mul_a=%h rsp_data=%h expected all 0",
               rsp_valid, busy, req_ready, mul_a, rsp_data);
    end
    sb.delete();
    grant_log.delete();
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    rst = 1'b0;
    tick();
    checks++;
    if (grant_log.size() < 1 || grant_log[0] != 0) begin
      errors++;
      $display("FAIL reset_ptr: first grant %0d expected 0",
               (grant_log.size() > 0) ? grant_log[0] : -1);
    end
    drain();
    $display("test_reset_mid done");
  endtask

`ifdef FP_MUL_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    stat_clr = 1'b0;
    rsp_ready = 1'b1;
    hold_mask = 4'b0100;
    req_valid = 4'b0100;
    repeat (70000) tick();
    checks++;
    if (stat_grants[2*16 +: 16] !== 16'hFFFF || stat_grants[0 +: 16] !== 16'h0) begin
      errors++;
      $display("FAIL stat_sat: cnt2=%h cnt0=%h expected FFFF 0000",
               stat_grants[2*16 +: 16], stat_grants[0 +: 16]);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    checks++;
    if (stat_grants !== '0) begin
      errors++;
      $display("FAIL stat_clr: got %h expected 0", stat_grants);
    end
    drain();
    $display("test_stats done");
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cfg = '0;
    rsp_ready = 1'b0;
    hold_mask = '0;
`ifdef FP_MUL_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
`ifdef FP_MUL_SCHED_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
